uart_echo_fifo: RTL
===================

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, FIFO entries (power of 2, 4..256); WIDTH, 8, data bits per entry.
REQ-002 Ports SHALL be, clock and reset first:
- i_clk  input  1  sole clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_wr_valid  input  1  one-cycle strobe from the UART receiver: byte valid.
- i_wr_data  input  WIDTH  received byte; sampled when i_wr_valid=1.
- i_tx_busy  input  1  UART transmitter busy.
- o_tx_start  output  1  one-cycle pulse to the transmitter: start sending o_tx_data.
- o_tx_data  output  WIDTH  byte to transmit; registered.
- o_count  output  $clog2(DEPTH)+1  current occupancy.
- o_empty  output  1  o_count==0.
- o_full  output  1  o_count==DEPTH.
- o_overflow  output  1  sticky; a write was dropped.
REQ-003 Clock and reset SHALL be exactly one clock, i_clk, and one asynchronous active-low reset, i_rst_n.

Function
REQ-004 A write SHALL occur in any cycle with i_wr_valid=1 and (o_full=0 or a pop in the same cycle); i_wr_data goes to the tail.
REQ-005 If i_wr_valid=1, o_full=1 and there is no pop in that cycle, the byte SHALL be dropped, the contents SHALL be unchanged and o_overflow SHALL be set to 1.
REQ-006 A simultaneous write and pop SHALL leave o_count unchanged, including at full and at count 1.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or go below 0.
REQ-008 The drain FSM SHALL have the states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-009 IDLE->START SHALL occur when o_empty=0 and i_tx_busy=0; the head SHALL be popped into o_tx_data on that edge.
REQ-010 In START, o_tx_start SHALL be 1 for exactly one cycle; next state SHALL be WAIT_BUSY.
REQ-011 WAIT_BUSY->WAIT_DONE SHALL occur when i_tx_busy=1; WAIT_DONE->IDLE SHALL occur when i_tx_busy=0.
REQ-012 With the FIFO empty and i_tx_busy=0, a byte strobed in cycle k SHALL produce o_tx_start=1 in cycle k+2, with o_tx_data equal to that byte.
REQ-013 o_tx_data SHALL hold its value from the pop until the next pop.
REQ-014 o_tx_start SHALL never be asserted outside START; at most one byte SHALL be in flight.
REQ-015 Bytes SHALL be transmitted in strict arrival order, without loss except for drops under REQ-005.

Reset
REQ-016 While i_rst_n=0: pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_tx_start=0, o_tx_data=0, FSM=IDLE.
REQ-017 Reset asserted mid-transmission SHALL abort the drain immediately; memory contents need not be cleared.
REQ-018 Reset SHALL be the only way to clear o_overflow.

Configuration
REQ-019 With UART_FIFO_OVF_CNT_EN defined, an extra output o_ovf_cnt (input/output direction: output, width 8) SHALL count dropped bytes, saturate at 255 and reset to 0.
REQ-020 Without UART_FIFO_OVF_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-021 Package uart_pkg SHALL hold: the default DEPTH and WIDTH constants, the drain-FSM state typedef (IDLE/START/WAIT_BUSY/WAIT_DONE), and the UART byte typedef.
REQ-022 Sub-module uart_fifo_mem SHALL implement the DEPTH x WIDTH register array: one synchronous write port and one synchronous read port, with no reset on storage.
REQ-023 Pointer, count, flag and FSM logic SHALL reside in uart_echo_fifo.

Verification
REQ-024 Single byte: reset; write 0x41 in cycle k with i_tx_busy=0 -> o_tx_start=1 in cycle k+2, o_tx_data=0x41, o_count returns to 0.
REQ-025 Ordering: write 0x10,0x11,0x12 back-to-back; model i_tx_busy high for 20 cycles after each start -> three starts in order 0x10,0x11,0x12; no start while busy.
REQ-026 Overflow: hold i_tx_busy=1; write 17 bytes 0x00..0x10 -> o_full=1 after 16; 17th dropped; o_overflow=1; o_ovf_cnt=1 when the macro is enabled; after release, 0x00..0x0F are output.
REQ-027 Full with simultaneous pop: DEPTH=16 full, write 0xAA in the same cycle as the IDLE->START pop -> o_count stays 16, o_overflow stays 0, and 0xAA is output last.
REQ-028 Wrap-around: stream 40 bytes with random busy lengths -> all 40 bytes are output in order, and o_count never exceeds 16.
REQ-029 Reset mid-operation: assert i_rst_n=0 during WAIT_DONE with 5 bytes queued -> all outputs take their REQ-016 values asynchronously, and there is no o_tx_start after release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART echo FIFO: default geometry, drain FSM states, byte type.
// Also holds the saturating increment used by the optional drop counter.
package uart_pkg;

   localparam int UART_DEPTH = 16;
   localparam int UART_WIDTH = 8;
   localparam int OVF_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } drain_state_t;

   typedef logic [UART_WIDTH-1:0] uart_byte_t;

   function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
      return (v == {OVF_CNT_W{1'b1}}) ? v : v + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one registered read port.
// Storage is not reset; only the read-data register clears so the transmit byte starts at zero.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_DEPTH,
   parameter int WIDTH = UART_WIDTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   // Read-before-write on a shared address: a pop at full sees the old head.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_data_q <= '0;
      end else if (i_rd_en) begin
         rd_data_q <= mem_q[i_rd_addr];
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo FIFO: RX bytes queue here and drain one per transmitter handshake; idle path RX k -> TX start k+2.
// Writes at full without a same-cycle pop are dropped (sticky o_overflow; o_ovf_cnt with UART_FIFO_OVF_CNT_EN).
module uart_echo_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_DEPTH,
   parameter int WIDTH = UART_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_wr_valid,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic                   i_tx_busy,
   output logic                   o_tx_start,
   output logic [WIDTH-1:0]       o_tx_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty,
   output logic                   o_full,
`ifdef UART_FIFO_OVF_CNT_EN
   output logic [OVF_CNT_W-1:0]   o_ovf_cnt,
`endif
   output logic                   o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   drain_state_t  state_q;
   logic          tx_start_q;
   logic          empty, full, pop, push, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   // Pops happen only from IDLE, which keeps a single byte in flight.
   assign pop   = (state_q == IDLE) && !empty && !i_tx_busy;
   assign push  = i_wr_valid && (!full || pop);
   assign drop  = i_wr_valid && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | drop;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q    <= START;
                  tx_start_q <= 1'b1;
               end
            end
            START: begin
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (i_tx_busy) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!i_tx_busy) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (push),
      .i_wr_addr (wr_ptr_q),
      .i_wr_data (i_wr_data),
      .i_rd_en   (pop),
      .i_rd_addr (rd_ptr_q),
      .o_rd_data (o_tx_data)
   );

`ifdef UART_FIFO_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop) begin
         ovf_cnt_d = sat_inc(ovf_cnt_q);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign o_ovf_cnt = ovf_cnt_q;
`endif

   assign o_tx_start = tx_start_q;
   assign o_count    = count_q;
   assign o_empty    = empty;
   assign o_full     = full;
   assign o_overflow = ovf_q;

   a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n) count_q <= FULL_CNT);
   a_start_state: assert property (@(posedge i_clk) disable iff (!i_rst_n) tx_start_q == (state_q == START));

endmodule
